// File: rtl/dcache_tbus_arb_pkg.sv
// Shared encodings for the dcache tbus arbiter: FSM states, request owner and
// tbus operation type.
package dcache_tbus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_LOAD  = 1'b0,
    OWNER_STORE = 1'b1
  } owner_e;

  typedef enum logic {
    TBUS_READ  = 1'b0,
    TBUS_WRITE = 1'b1
  } tbus_optype_e;

  localparam int TBUS_OPTYPE_W = $bits(tbus_optype_e);

  // Bit positions of the one-hot grant vector.
  localparam int GRANT_LOAD  = 0;
  localparam int GRANT_STORE = 1;

endpackage

// File: rtl/dcache_tbus_arb_if.sv
// Load-unit, store-queue and dcache tbus signals of the arbiter; the master
// modport is the arbiter's view, slave is the surrounding load/store/dcache side.
interface dcache_tbus_arb_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  import dcache_tbus_arb_pkg::*;

  logic              load_req_valid;
  logic              load_req_ready;
  logic [ADDR_W-1:0] load_req_index;
  logic              load_resp_valid;
  logic [DATA_W-1:0] load_resp_data;

  logic              sq_req_valid;
  logic              sq_req_ready;
  logic [ADDR_W-1:0] sq_req_index;
  logic [DATA_W-1:0] sq_req_write_data;
  logic [DATA_W-1:0] sq_req_write_mask;
  logic              sq_resp_done;

  logic              flush_valid;

  logic              tbus_index_valid;
  logic              tbus_index_ready;
  logic [ADDR_W-1:0] tbus_index;
  logic [DATA_W-1:0] tbus_write_data;
  logic [DATA_W-1:0] tbus_write_mask;
  tbus_optype_e      tbus_operation_type;
  logic [DATA_W-1:0] tbus_read_data;
  logic              tbus_operation_done;

  modport master (
    input  load_req_valid, load_req_index,
    input  sq_req_valid, sq_req_index, sq_req_write_data, sq_req_write_mask,
    input  flush_valid,
    input  tbus_index_ready, tbus_read_data, tbus_operation_done,
    output load_req_ready, load_resp_valid, load_resp_data,
    output sq_req_ready, sq_resp_done,
    output tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask,
    output tbus_operation_type
  );

  modport slave (
    output load_req_valid, load_req_index,
    output sq_req_valid, sq_req_index, sq_req_write_data, sq_req_write_mask,
    output flush_valid,
    output tbus_index_ready, tbus_read_data, tbus_operation_done,
    input  load_req_ready, load_resp_valid, load_resp_data,
    input  sq_req_ready, sq_resp_done,
    input  tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask,
    input  tbus_operation_type
  );

endinterface

// File: rtl/dcache_tbus_arb_sel.sv
// Grant selection between load and store requesters (one-hot grant).
// Define TBUS_ARB_RR_EN for round-robin; the default build gives load fixed priority.
module tbus_arb_sel
  import dcache_tbus_arb_pkg::*;
(
  input  logic       load_valid,
  input  logic       store_valid,
  input  owner_e     last_grant,
  input  logic       flush,
  output logic [1:0] grant
);

  logic load_ok;

  // A flush in the acceptance cycle would kill the load immediately, so never grant it.
  assign load_ok = load_valid & ~flush;

`ifdef TBUS_ARB_RR_EN
  always_comb begin
    grant = 2'b00;
    if (load_ok && store_valid) begin
      if (last_grant == OWNER_LOAD) grant[GRANT_STORE] = 1'b1;
      else                          grant[GRANT_LOAD]  = 1'b1;
    end else if (load_ok) begin
      grant[GRANT_LOAD] = 1'b1;
    end else if (store_valid) begin
      grant[GRANT_STORE] = 1'b1;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = 2'b00;
    if (load_ok)          grant[GRANT_LOAD]  = 1'b1;
    else if (store_valid) grant[GRANT_STORE] = 1'b1;
  end
`endif

endmodule

// File: rtl/dcache_tbus_arb.sv
// Arbitrates load-unit reads and store-queue writes onto the single dcache tbus port.
// Policy lives in tbus_arb_sel; TBUS_ARB_RR_EN selects round-robin instead of load priority.
//
//   state | meaning
//   IDLE  | no request owned; may accept one requester
//   REQ   | request latched, tbus_index_valid high until tbus_index_ready
//   WAIT  | request issued to dcache, awaiting tbus_operation_done
module dcache_tbus_arb
  import dcache_tbus_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  dcache_tbus_arb_if.master bus
);

  arb_state_e        state;
  owner_e            owner;
  owner_e            last_grant;
  logic              killed;
  logic              index_valid;
  logic [ADDR_W-1:0] index_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wmask_q;
  tbus_optype_e      optype_q;

  logic [1:0] grant;
  logic       accept_load;
  logic       accept_store;
  logic       kill_now;
  logic       complete;
  logic       load_resp;

  tbus_arb_sel u_sel (
    .load_valid  (bus.load_req_valid),
    .store_valid (bus.sq_req_valid),
    .last_grant  (last_grant),
    .flush       (bus.flush_valid),
    .grant       (grant)
  );

  // Readies are gated by reset_n so they read 0 while reset is held.
  assign accept_load  = reset_n & (state == IDLE) & grant[GRANT_LOAD];
  assign accept_store = reset_n & (state == IDLE) & grant[GRANT_STORE];
  assign kill_now     = bus.flush_valid & (owner == OWNER_LOAD);
  assign complete     = reset_n & bus.tbus_operation_done &
                        ((state == WAIT) | ((state == REQ) & bus.tbus_index_ready));
  assign load_resp    = complete & (owner == OWNER_LOAD) & ~killed & ~bus.flush_valid;

  assign bus.load_req_ready      = accept_load;
  assign bus.sq_req_ready        = accept_store;
  assign bus.load_resp_valid     = load_resp;
  assign bus.load_resp_data      = load_resp ? bus.tbus_read_data : '0;
  assign bus.sq_resp_done        = complete & (owner == OWNER_STORE);
  assign bus.tbus_index_valid    = index_valid;
  assign bus.tbus_index          = index_q;
  assign bus.tbus_write_data     = wdata_q;
  assign bus.tbus_write_mask     = wmask_q;
  assign bus.tbus_operation_type = optype_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= OWNER_LOAD;
      last_grant  <= OWNER_STORE;
      killed      <= 1'b0;
      index_valid <= 1'b0;
      index_q     <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      optype_q    <= TBUS_READ;
    end else begin
      case (state)
        IDLE: begin
          if (accept_load || accept_store) begin
            state       <= REQ;
            index_valid <= 1'b1;
            killed      <= 1'b0;
            if (accept_load) begin
              owner      <= OWNER_LOAD;
              last_grant <= OWNER_LOAD;
              optype_q   <= TBUS_READ;
              index_q    <= bus.load_req_index;
              wdata_q    <= '0;
              wmask_q    <= '0;
            end else begin
              owner      <= OWNER_STORE;
              last_grant <= OWNER_STORE;
              optype_q   <= TBUS_WRITE;
              index_q    <= bus.sq_req_index;
              wdata_q    <= bus.sq_req_write_data;
              wmask_q    <= bus.sq_req_write_mask;
            end
          end
        end
        REQ: begin
          // If the dcache took the index in the flush cycle, a done is still coming:
          // wait for it as a killed load rather than abandoning it.
          if (bus.tbus_index_ready) begin
            index_valid <= 1'b0;
            if (bus.tbus_operation_done) begin
              state <= IDLE;
            end else begin
              state  <= WAIT;
              killed <= kill_now;
            end
          end else if (kill_now) begin
            index_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        WAIT: begin
          if (bus.tbus_operation_done) begin
            state  <= IDLE;
            killed <= 1'b0;
          end else if (kill_now) begin
            killed <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          index_valid <= 1'b0;
          killed      <= 1'b0;
        end
      endcase
    end
  end

endmodule
